fns_encoder_seq: RTL and testbench

- Sequential Fibonacci-numeral-system (FNS) encoder. It converts a binary data word into a CODE_W-bit Fibonacci codeword, resolving one codeword bit per clock, MSB first, by greedy subtraction.
- It sits on the transmit side of the crosstalk-avoidance link and is the forward counterpart of the Fibonacci adder-chain decoder stages. Applying decoder(encoder(x)) must return x for every legal x.
- Valid/ready handshake on both sides.

---
 rtl/fns_encoder_seq.sv | 118 +++++++++++
 tb/tb_fns_encoder_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fns_encoder_seq.sv
// Fibonacci (Zeckendorf) encoder: greedy subtraction, one codeword bit per clock, MSB first.
// Latency CODE_W clocks from accept to out_valid; in_ready stays low until the output handshake.
module fns_encoder_seq #(
    parameter int DATA_W = 8,
    parameter int CODE_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    output logic              code_err,
    output logic              busy
);
    function automatic int fib(input int k);
        int a;
        int b;
        int t;
        a = 1;
        b = 2;
        if (k == 0) return 1;
        for (int i = 1; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    localparam int F_TOP  = fib(CODE_W);
    localparam int F_BITS = $clog2(F_TOP + 1);
    localparam int REM_W  = (DATA_W > F_BITS) ? DATA_W : F_BITS;
    localparam int IDX_W  = $clog2(CODE_W + 1);

    typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

    state_t            state;
    logic [REM_W-1:0]  rem;
    logic [IDX_W-1:0]  idx;
    logic [CODE_W-1:0] code_q;
    logic              err;
    logic [REM_W-1:0]  data_ext;
    logic [REM_W-1:0]  weight [CODE_W+1];
    logic              take;

    // weight[CODE_W] is the first value that no longer fits in CODE_W bits
    for (genvar k = 0; k <= CODE_W; k++) begin : g_weight
        assign weight[k] = REM_W'(fib(k));
    end

    assign data_ext = REM_W'(data_in);
    assign take     = (rem >= weight[idx]);
    assign code_out = code_q;
    assign code_err = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            code_q    <= '0;
            err       <= 1'b0;
            rem       <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem      <= data_ext;
                        idx      <= IDX_W'(CODE_W - 1);
                        code_q   <= '0;
                        err      <= (data_ext >= weight[CODE_W]);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ENC;
                    end
                end
                ENC: begin
                    // an overflowed word keeps the cleared codeword, only the timing runs on
                    if (!err && take) begin
                        code_q[idx] <= 1'b1;
                        rem         <= rem - weight[idx];
                    end
                    if (idx == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Greedy invariant rem < f(idx+1) is what rules out two adjacent ones.
    always_ff @(posedge clk) begin
        if (!rst && state == ENC && !err) begin
            assert (rem < weight[idx + 1'b1]);
        end
        if (!rst && state == DONE && !err) begin
            assert (rem == '0);
            assert ((code_q & (code_q >> 1)) == '0);
        end
    end
endmodule

// File: tb/tb_fns_encoder_seq.sv
// Bench for fns_encoder_seq: default instance plus a DATA_W=9 instance for the overflow cases.
module tb_fns_encoder_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, code_err, busy;
    logic [7:0]  data_in;
    logic [11:0] code_out;
    logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_code_err, o_busy;
    logic [8:0]  o_data_in;
    logic [11:0] o_code_out;

    fns_encoder_seq u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
        .code_err(code_err), .busy(busy)
    );

    fns_encoder_seq #(.DATA_W(9), .CODE_W(12)) u_ovf (
        .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready), .data_in(o_data_in),
        .out_valid(o_out_valid), .out_ready(o_out_ready), .code_out(o_code_out),
        .code_err(o_code_err), .busy(o_busy)
    );

    typedef struct {
        logic [8:0]  din;
        logic [11:0] code;
        logic        err;
        int          hold;
    } vec_t;

    vec_t        sb[$];
    vec_t        dtab[7];
    vec_t        otab[5];
    int          vectors = 0;
    int          miscompares = 0;
    int          viol = 0;
    int          wt[13];
    logic [11:0] lut[377];
    logic [11:0] cc;

    always @(negedge clk) begin
        if ((in_ready && out_valid) || (o_in_ready && o_out_valid)) viol++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    function automatic int decode(input logic [11:0] c);
        int s;
        s = 0;
        for (int k = 0; k < 12; k++) if (c[k]) s += wt[k];
        return s;
    endfunction

    function automatic logic f_in_ready(input bit o);  return o ? o_in_ready : in_ready;   endfunction
    function automatic logic f_out_valid(input bit o); return o ? o_out_valid : out_valid; endfunction
    function automatic logic f_err(input bit o);       return o ? o_code_err : code_err;   endfunction
    function automatic logic f_busy(input bit o);      return o ? o_busy : busy;           endfunction
    function automatic logic [11:0] f_code(input bit o); return o ? o_code_out : code_out; endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit o, input logic v, input logic [8:0] d);
        if (o) begin
            o_in_valid = v;
            o_data_in  = d;
        end else begin
            in_valid = v;
            data_in  = d[7:0];
        end
    endtask

    task automatic set_ready(input bit o, input logic r);
        if (o) o_out_ready = r;
        else   out_ready   = r;
    endtask

    // Called while out_valid is high and out_ready is high for the coming edge.
    task automatic pop_check(input bit o);
        vec_t        e;
        logic [11:0] c;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        c = f_code(o);
        check("code", int'(c), int'(e.code));
        check("err", int'(f_err(o)), int'(e.err));
        if (!e.err) begin
            check("decode", decode(c), int'(e.din));
            check("adjacent", int'(c & (c >> 1)), 0);
        end
    endtask

    task automatic wait_valid(input bit o, output int n);
        n = 0;
        while (!f_out_valid(o) && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic run_vec(input bit o, input vec_t v);
        int n;
        n = 0;
        while (!f_in_ready(o) && n < 50) begin
            step();
            n++;
        end
        check("accept_wait", int'(n < 50), 1);
        drive(o, 1'b1, v.din);
        sb.push_back(v);
        step();
        drive(o, 1'b0, 9'd0);
        check("busy_enc", int'(f_busy(o)), 1);
        check("in_ready_enc", int'(f_in_ready(o)), 0);
        wait_valid(o, n);
        check("latency", n, 12);
        for (int i = 0; i < v.hold; i++) begin
            step();
            check("hold_valid", int'(f_out_valid(o)), 1);
            check("hold_code", int'(f_code(o)), int'(v.code));
            check("hold_in_ready", int'(f_in_ready(o)), 0);
        end
        set_ready(o, 1'b1);
        pop_check(o);
        step();
        set_ready(o, 1'b0);
        check("post_valid", int'(f_out_valid(o)), 0);
        check("post_in_ready", int'(f_in_ready(o)), 1);
    endtask

    task automatic drive_all();
        int n;
        for (int v = 0; v < 256; v++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) begin
                check("drv_timeout", n, 0);
                return;
            end
            drive(1'b0, 1'b1, 9'(v));
            sb.push_back('{9'(v), lut[v], 1'b0, 0});
            step();
            drive(1'b0, 1'b0, 9'd0);
        end
    endtask

    task automatic monitor_all();
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 256 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                pop_check(1'b0);
                got++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("exh_count", got, 256);
    endtask

    initial begin
        int n;
        int seen;
        dtab[0] = '{9'd255, 12'h841, 1'b0, 0};
        dtab[1] = '{9'd100, 12'h214, 1'b0, 5};
        dtab[2] = '{9'd0,   12'h000, 1'b0, 0};
        dtab[3] = '{9'd1,   12'h001, 1'b0, 0};
        dtab[4] = '{9'd2,   12'h002, 1'b0, 2};
        dtab[5] = '{9'd232, 12'h555, 1'b0, 0};
        dtab[6] = '{9'd254, 12'h840, 1'b0, 0};
        otab[0] = '{9'd400, 12'h000, 1'b1, 0};
        otab[1] = '{9'd10,  12'h012, 1'b0, 0};
        otab[2] = '{9'd377, 12'h000, 1'b1, 3};
        otab[3] = '{9'd376, 12'hAAA, 1'b0, 0};
        otab[4] = '{9'd0,   12'h000, 1'b0, 0};

        // Reference: decode every adjacency-free codeword; Zeckendorf uniqueness gives the inverse.
        wt[0] = 1;
        wt[1] = 2;
        for (int k = 2; k < 13; k++) wt[k] = wt[k-1] + wt[k-2];
        for (int c = 0; c < 4096; c++) begin
            cc = 12'(c);
            if ((cc & (cc >> 1)) == 12'h000) lut[decode(cc)] = cc;
        end

        rst = 1'b1;
        in_valid = 1'b0; data_in = 8'd0; out_ready = 1'b0;
        o_in_valid = 1'b0; o_data_in = 9'd0; o_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_code", int'(code_out), 0);
        check("rst_err", int'(code_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_o_in_ready", int'(o_in_ready), 1);

        for (int i = 0; i < 7; i++) run_vec(1'b0, dtab[i]);
        for (int i = 0; i < 5; i++) run_vec(1'b1, otab[i]);

        // in_valid held through ENC/DONE and out_ready raised early
        drive(1'b0, 1'b1, 9'd1);
        sb.push_back('{9'd1, 12'h001, 1'b0, 0});
        step();
        drive(1'b0, 1'b1, 9'd2);
        sb.push_back('{9'd2, 12'h002, 1'b0, 0});
        out_ready = 1'b1;
        wait_valid(1'b0, n);
        check("early_ready_latency", n, 12);
        pop_check(1'b0);
        step();
        check("held_in_ready", int'(in_ready), 1);
        step();
        check("held_accepted", int'(in_ready), 0);
        drive(1'b0, 1'b0, 9'd0);
        wait_valid(1'b0, n);
        check("held_latency", n, 12);
        pop_check(1'b0);
        step();
        out_ready = 1'b0;

        // Reset during the 4th ENC cycle discards the word
        drive(1'b0, 1'b1, 9'd255);
        sb.push_back('{9'd255, 12'h841, 1'b0, 0});
        step();
        drive(1'b0, 1'b0, 9'd0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_front());
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_code", int'(code_out), 0);
        check("mid_rst_busy", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("mid_rst_no_output", seen, 0);

        fork
            drive_all();
            monitor_all();
        join

        check("sb_drained", sb.size(), 0);
        check("no_in_ready_with_out_valid", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
